// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream stage.
package fifo_pkg;

  // Default data width used by the stream stage and its buffer.
  localparam int DATA_WIDTH = 8;

  // Width of the beat and frame counters.
  localparam int CNT_WIDTH = 16;

  typedef logic [DATA_WIDTH-1:0] data_t;

  // Buffer occupancy doubles as the buffer's state encoding.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Number of buffered beats for a given occupancy state.
  function automatic logic [1:0] occ_count(input occ_e s);
    case (s)
      OCC_ONE: return 2'd1;
      OCC_TWO: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry ordered buffer. Entry 0 is always the head; entry 1 holds the
// second-oldest beat when two are buffered. Push and pop may coincide.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output occ_e          occ,
  output logic [DW-1:0] head_data
);

  genvar gi;

  occ_e                occ_reg;
  occ_e                occ_next;
  logic [1:0]          load_en;
  logic [1:0][DW-1:0]  load_val;
  logic [1:0][DW-1:0]  entry_q;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_reg <= OCC_EMPTY;
    end else begin
      occ_reg <= occ_next;
    end
  end

  // Occupancy next state: push adds a beat, pop removes one, both together hold.
  always_comb begin
    occ_next = occ_reg;
    case (occ_reg)
      OCC_EMPTY: begin
        if (push) occ_next = OCC_ONE;
      end
      OCC_ONE: begin
        if (push && !pop)      occ_next = OCC_TWO;
        else if (pop && !push) occ_next = OCC_EMPTY;
      end
      OCC_TWO: begin
        if (pop && !push) occ_next = OCC_ONE;
      end
      default: occ_next = OCC_EMPTY;
    endcase
  end

  // Entry write selection: new data lands in the first free slot after any pop;
  // a pop from two entries shifts entry 1 into the head.
  always_comb begin
    load_en     = 2'b00;
    load_val[0] = push_data;
    load_val[1] = push_data;
    case (occ_reg)
      OCC_EMPTY: begin
        load_en[0] = push;
      end
      OCC_ONE: begin
        load_en[0] = push && pop;
        load_en[1] = push && !pop;
      end
      OCC_TWO: begin
        load_en[0]  = pop;
        load_val[0] = entry_q[1];
        load_en[1]  = push && pop;
      end
      default: begin
        load_en = 2'b00;
      end
    endcase
  end

  // One storage register per entry.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [DW-1:0] entry_reg;

      // Load the entry when selected; cleared so the head reads zero out of reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (load_en[gi]) begin
          entry_reg <= load_val[gi];
        end
      end

      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  assign occ       = occ_reg;
  assign head_data = entry_q[0];

  // A push into a full buffer without a pop would lose a beat; upstream issue
  // logic must make this impossible.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(push && !pop && occ_reg == OCC_TWO));

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: issues reads to the FIFO, absorbs the one-cycle read
// latency in a 2-entry buffer and presents the data as a framed valid/ready stream.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int FRAME_LEN  = 4
) (
  input  logic                  rdclk,
  input  logic                  rrst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [15:0]           frame_cnt
);

  localparam logic [15:0] LAST_BEAT = 16'(FRAME_LEN - 1);

  logic        run_reg;
  logic        infl_reg;
  logic [15:0] beat_cnt_reg;
  logic [15:0] frame_cnt_reg;
  occ_e        occ;
  logic        pop;
  logic        capture;
  logic [2:0]  occ_after;

  assign pop     = m_valid && m_ready;
  assign capture = infl_reg;
  assign m_valid = (occ != OCC_EMPTY);
  assign m_last  = m_valid && (beat_cnt_reg == LAST_BEAT);

  // Occupancy this read would see once it lands: current beats plus the one
  // arriving now, minus the one leaving now. Pop depends on m_ready
  // combinationally so a freed slot can be refilled in the same cycle.
  always_comb begin
    occ_after = {1'b0, occ_count(occ)} + {2'b00, infl_reg} - {2'b00, pop};
  end

  assign rd_en = run_reg && enable && !fifo_empty && (occ_after < 3'd2);

  // Run flag holds off reads for the first edge after reset release.
  always_ff @(posedge rdclk or negedge rrst_n) begin
    if (!rrst_n) begin
      run_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
    end
  end

  // Track the read whose data arrives on the next cycle; it is always captured.
  always_ff @(posedge rdclk or negedge rrst_n) begin
    if (!rrst_n) begin
      infl_reg <= 1'b0;
    end else begin
      infl_reg <= rd_en;
    end
  end

  // Beat position within the frame, advanced on every accepted beat.
  always_ff @(posedge rdclk or negedge rrst_n) begin
    if (!rrst_n) begin
      beat_cnt_reg <= '0;
    end else if (pop) begin
      if (beat_cnt_reg == LAST_BEAT) begin
        beat_cnt_reg <= '0;
      end else begin
        beat_cnt_reg <= beat_cnt_reg + 16'd1;
      end
    end
  end

  // Completed frame counter, wrapping naturally at 2^16.
  always_ff @(posedge rdclk or negedge rrst_n) begin
    if (!rrst_n) begin
      frame_cnt_reg <= '0;
    end else if (pop && m_last) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_reg;

  skid_buf2 #(
    .DW (DATA_WIDTH)
  ) u_buf (
    .clk       (rdclk),
    .rst_n     (rrst_n),
    .push      (capture),
    .push_data (fifo_rdata),
    .pop       (pop),
    .occ       (occ),
    .head_data (m_data)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue models the FIFO, a scoreboard queue holds
// beats in read order, and a monitor checks every accepted beat and framing.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int FL = 4;

  logic          rdclk = 1'b0;
  logic          rrst_n;
  logic          enable;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic [15:0]   frame_cnt;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] fq[$];   // words held by the modelled FIFO
  logic [DW-1:0] sb[$];   // beats expected on the stream, in order
  int            exp_beat   = 0;
  int            exp_frames = 0;
  logic          last_rd_en;
  logic          last_valid;

  always #5 rdclk = ~rdclk;

  fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .FRAME_LEN  (FL)
  ) dut (
    .rdclk      (rdclk),
    .rrst_n     (rrst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .rd_en      (rd_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .frame_cnt  (frame_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge. Inputs are applied,
  // rd_en is sampled, and a granted read returns data just after the rising edge.
  task automatic cycle(input logic rdy, input logic en);
    logic          issued;
    logic [DW-1:0] d;
    m_ready    = rdy;
    enable     = en;
    fifo_empty = (fq.size() == 0);
    #1;
    last_rd_en = rd_en;
    last_valid = m_valid;
    issued     = rd_en;
    d          = '0;
    if (issued) begin
      check("rd_en_while_empty", fifo_empty, 0);
      if (fq.size() > 0) begin
        d = fq.pop_front();
        sb.push_back(d);
      end
    end
    @(posedge rdclk);
    #1;
    fifo_rdata = issued ? d : DW'($urandom);
    @(negedge rdclk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fq.size() > 0 || sb.size() > 0) && n < budget) begin
      cycle(1'b1, 1'b1);
      n++;
    end
    check("drain_scoreboard", sb.size(), 0);
    check("drain_fifo", fq.size(), 0);
    check("idle_valid", m_valid, 0);
  endtask

  // Monitor: compares each accepted beat against the scoreboard and checks
  // that a stalled beat is held stable.
  initial begin : monitor
    logic          pv, pr, pl;
    logic [DW-1:0] pd;
    logic [DW-1:0] e;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    forever begin
      @(negedge rdclk);
      #2;
      if (rrst_n !== 1'b1) begin
        pv = 1'b0;
        continue;
      end
      if (pv && !pr) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, pd);
        check("hold_last", m_last, pl);
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat actual=%0h required=no_beat", m_data);
        end else begin
          e = sb.pop_front();
          $display("beat data=%02h last=%0d frame_cnt=%0d", m_data, m_last, frame_cnt);
          check("beat_data", m_data, e);
          check("beat_last", m_last, (exp_beat == FL - 1));
          check("frame_cnt", frame_cnt, exp_frames);
          if (exp_beat == FL - 1) begin
            exp_beat   = 0;
            exp_frames = (exp_frames + 1) % 65536;
          end else begin
            exp_beat++;
          end
        end
      end
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin : stimulus
    logic rds[12];
    logic vld[12];
    int   nv, first, lastv, n;

    rrst_n     = 1'b0;
    enable     = 1'b1;
    m_ready    = 1'b1;
    fifo_rdata = '0;
    for (int i = 1; i <= 8; i++) fq.push_back(DW'(i));
    fifo_empty = 1'b0;

    // Reset held with a non-empty FIFO.
    repeat (3) @(negedge rdclk);
    #1;
    check("reset_rd_en", rd_en, 0);
    check("reset_m_valid", m_valid, 0);
    check("reset_m_last", m_last, 0);
    check("reset_frame_cnt", frame_cnt, 0);
    check("reset_m_data", m_data, 0);

    // Release and stream 0x01..0x08 with the sink always ready.
    @(negedge rdclk);
    rrst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b1);
      rds[i] = last_rd_en;
      vld[i] = last_valid;
    end
    check("first_edge_no_rd_en", rds[0], 0);
    check("second_edge_rd_en", rds[1], 1);
    nv = 0; first = -1; lastv = -1;
    for (int i = 0; i < 12; i++) begin
      if (vld[i]) begin
        nv++;
        if (first < 0) first = i;
        lastv = i;
      end
    end
    check("stream_beats", nv, 8);
    check("stream_no_bubbles", lastv - first + 1, 8);
    check("stream_latency", first, 3);
    check("stream_frames", frame_cnt, 2);

    // Backpressure mid-stream.
    for (int i = 0; i < 8; i++) fq.push_back(DW'(8'h10 + i));
    repeat (3) cycle(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1);
      check("stall_rd_en", last_rd_en, 0);
      check("stall_valid", last_valid, 1);
    end
    cycle(1'b1, 1'b1);
    check("restart_rd_en", last_rd_en, 1);
    drain(100);

    // Single word, then the FIFO runs empty.
    fq.push_back(8'hA5);
    cycle(1'b1, 1'b1);
    check("single_read", last_rd_en, 1);
    cycle(1'b1, 1'b1);
    check("empty_no_read", last_rd_en, 0);
    cycle(1'b1, 1'b1);
    check("a5_valid", last_valid, 1);
    check("a5_no_read", last_rd_en, 0);
    cycle(1'b1, 1'b1);
    check("a5_gone", last_valid, 0);
    check("a5_scoreboard", sb.size(), 0);

    // Enable falls right after a read is issued.
    fq.push_back(8'h30); fq.push_back(8'h31); fq.push_back(8'h32);
    cycle(1'b0, 1'b1);
    check("en_read_issued", last_rd_en, 1);
    cycle(1'b0, 1'b0);
    check("en_low_no_read", last_rd_en, 0);
    cycle(1'b0, 1'b0);
    check("en_inflight_valid", last_valid, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0);
      check("en_low_no_read", last_rd_en, 0);
    end
    check("en_inflight_delivered", sb.size(), 0);
    check("en_fifo_left", fq.size(), 2);
    drain(100);

    // Reset in the middle of a frame.
    for (int i = 0; i < 16; i++) fq.push_back(DW'(8'h40 + i));
    n = 0;
    while ((n < 3 || exp_beat != 2) && n < 40) begin
      cycle(1'b1, 1'b1);
      n++;
    end
    check("reach_beat2", exp_beat, 2);
    rrst_n = 1'b0;
    #1;
    check("midrst_rd_en", rd_en, 0);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_m_last", m_last, 0);
    check("midrst_m_data", m_data, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    sb.delete();
    exp_beat   = 0;
    exp_frames = 0;
    @(negedge rdclk);
    repeat (2) cycle(1'b1, 1'b1);
    rrst_n = 1'b1;
    repeat (8) cycle(1'b1, 1'b1);
    check("midrst_first_frame", frame_cnt, 1);
    drain(100);

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) fq.push_back(DW'($urandom));
      cycle(logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 9) < 8));
    end
    drain(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
